// File: rtl/alu_word_seq.sv
// Word-serial controller for a single 4-bit 74181-style ALU slice.
// Processes one nibble per cycle, LSB first, and ripples the slice carry between nibbles.
module alu_word_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             aeqb,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic [3:0]       slice_s,
  output logic             slice_m,
  output logic             slice_cn,
  input  logic [3:0]       slice_f,
  input  logic             slice_cn4,
  input  logic             slice_aeqb
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, result_reg, result_next;
  logic [3:0]       s_reg;
  logic             m_reg, carry_reg, acc_reg;
  logic [IDXW-1:0]  idx_reg;
  logic [3:0]       a_nib [NSLICE];
  logic [3:0]       b_nib [NSLICE];

  // Per-nibble views of the latched operands and the nibble-wise result update.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[4*gi +: 4];
    assign b_nib[gi] = b_reg[4*gi +: 4];
    assign result_next[4*gi +: 4] = (state_reg == RUN && idx_reg == IDXW'(gi)) ?
                                    slice_f : result_reg[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= '0;
      m_reg      <= 1'b0;
      carry_reg  <= 1'b0;
      acc_reg    <= 1'b0;
      idx_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            s_reg     <= s;
            m_reg     <= m;
            carry_reg <= cin;
            acc_reg   <= 1'b1;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          // Carry chains in logic mode too; the slice decides whether it matters.
          result_reg <= result_next;
          carry_reg  <= slice_cn4;
          acc_reg    <= acc_reg & slice_aeqb;
          if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    slice_a = 4'h0;
    slice_b = 4'h0;
    case (state_reg)
      RUN: begin
        busy    = 1'b1;
        slice_a = a_nib[idx_reg];
        slice_b = b_nib[idx_reg];
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign slice_s  = s_reg;
  assign slice_m  = m_reg;
  assign slice_cn = carry_reg;
  assign result   = result_reg;
  assign cout     = carry_reg;
  assign aeqb     = acc_reg;

endmodule

// File: tb/tb_alu_word_seq.sv
// Bench for alu_word_seq: gate-style 74181 slice model on the slice port,
// word-level datasheet function table as the reference.
module tb_alu_word_seq;
  localparam int WIDTH = 16;
  localparam int NSLICE = WIDTH / 4;

  logic clk = 1'b0;
  logic rst, start;
  logic [WIDTH-1:0] a, b;
  logic [3:0] s;
  logic m, cin;
  logic busy, done, cout, aeqb;
  logic [WIDTH-1:0] result;
  logic [3:0] slice_a, slice_b, slice_s, slice_f;
  logic slice_m, slice_cn, slice_cn4, slice_aeqb;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_word_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .aeqb(aeqb),
    .slice_a(slice_a), .slice_b(slice_b), .slice_s(slice_s), .slice_m(slice_m),
    .slice_cn(slice_cn), .slice_f(slice_f), .slice_cn4(slice_cn4), .slice_aeqb(slice_aeqb)
  );

  // One 74181 slice, active-high data, Cn = 1 means no carry.
  logic [3:0] sx, sy;
  logic [4:0] ssum;
  always_comb begin
    sx = slice_a | ({4{slice_s[0]}} & slice_b) | ({4{slice_s[1]}} & ~slice_b);
    sy = ({4{slice_s[2]}} & slice_a & ~slice_b) | ({4{slice_s[3]}} & slice_a & slice_b);
    ssum = {1'b0, sx} + {1'b0, sy} + {4'b0, ~slice_cn};
    slice_f = slice_m ? ~(sx ^ sy) : ssum[3:0];
    slice_cn4 = ~ssum[4];
    slice_aeqb = &slice_f;
  end

  // Word-level reference: returns {aeqb, cout, F}.
  function automatic logic [WIDTH+1:0] ref_op(input logic [WIDTH-1:0] ra, rb,
                                              input logic [3:0] rs, input logic rm, rcin);
    logic [WIDTH-1:0] p, q, f, ones;
    logic [WIDTH:0] sum;
    ones = '1;
    q = '0;
    case (rs)
      4'd0:  p = ra;
      4'd1:  p = ra | rb;
      4'd2:  p = ra | ~rb;
      4'd3:  p = ones;
      4'd4:  begin p = ra;        q = ra & ~rb; end
      4'd5:  begin p = ra | rb;   q = ra & ~rb; end
      4'd6:  begin p = ra;        q = ~rb;      end
      4'd7:  begin p = ra & ~rb;  q = ones;     end
      4'd8:  begin p = ra;        q = ra & rb;  end
      4'd9:  begin p = ra;        q = rb;       end
      4'd10: begin p = ra | ~rb;  q = ra & rb;  end
      4'd11: begin p = ra & rb;   q = ones;     end
      4'd12: begin p = ra;        q = ra;       end
      4'd13: begin p = ra | rb;   q = ra;       end
      4'd14: begin p = ra | ~rb;  q = ra;       end
      default: begin p = ra;      q = ones;     end
    endcase
    sum = {1'b0, p} + {1'b0, q} + {{WIDTH{1'b0}}, ~rcin};
    if (rm) begin
      case (rs)
        4'd0:  f = ~ra;
        4'd1:  f = ~(ra | rb);
        4'd2:  f = ~ra & rb;
        4'd3:  f = '0;
        4'd4:  f = ~(ra & rb);
        4'd5:  f = ~rb;
        4'd6:  f = ra ^ rb;
        4'd7:  f = ra & ~rb;
        4'd8:  f = ~ra | rb;
        4'd9:  f = ~(ra ^ rb);
        4'd10: f = rb;
        4'd11: f = ra & rb;
        4'd12: f = ones;
        4'd13: f = ra | ~rb;
        4'd14: f = ra | rb;
        default: f = ra;
      endcase
    end else begin
      f = sum[WIDTH-1:0];
    end
    return {&f, ~sum[WIDTH], f};
  endfunction

  // Drives one request and waits (bounded) for done; lat = -1 on timeout.
  task automatic run_op(input logic [WIDTH-1:0] ta, tb_, input logic [3:0] ts,
                        input logic tm, tcin, input bit scramble,
                        output logic [WIDTH+1:0] got, output int lat, output logic [3:0] cn_seq);
    int n;
    @(negedge clk);
    a = ta; b = tb_; s = ts; m = tm; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    cn_seq = '0;
    if (scramble) begin
      a = '1; b = ~b; s = ~s; m = ~m; cin = ~cin;
    end
    while (!done && n < 20) begin
      if (n <= NSLICE) cn_seq[n-1] = slice_cn;
      @(negedge clk);
      n++;
    end
    lat = done ? n : -1;
    got = {aeqb, cout, result};
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1;
    a = 16'h1234; b = 16'h5678; s = 4'b1001; m = 1'b0; cin = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, cout, aeqb} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, done, cout, aeqb});
    end
    total++;
    if (result !== 16'h0000) begin
      bad++;
      $display("FAIL reset_result got=%h exp=0000", result);
    end
    total++;
    if ({slice_a, slice_b, slice_s, slice_m, slice_cn} !== 14'h0) begin
      bad++;
      $display("FAIL reset_slice got=%h exp=0", {slice_a, slice_b, slice_s, slice_m, slice_cn});
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] va [5] = '{16'h1234, 16'hFFFF, 16'hA5A5, 16'h3C3C, 16'h3C3C};
    logic [WIDTH-1:0] vb [5] = '{16'h0FFF, 16'h0001, 16'hA5A5, 16'h3C3C, 16'h3C3B};
    logic [3:0] vs [5] = '{4'b1001, 4'b1001, 4'b0110, 4'b0110, 4'b0110};
    logic vm [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [WIDTH-1:0] vr [5] = '{16'h2233, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    logic [WIDTH+1:0] got, expv;
    logic [3:0] cn_seq;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vs[i], vm[i], 1'b1, 1'b0, got, lat, cn_seq);
      expv = ref_op(va[i], vb[i], vs[i], vm[i], 1'b1);
      total++;
      if (lat !== NSLICE + 1) begin
        bad++;
        $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NSLICE + 1);
      end
      total++;
      if (got[WIDTH-1:0] !== vr[i]) begin
        bad++;
        $display("FAIL dir%0d_result got=%h exp=%h", i, got[WIDTH-1:0], vr[i]);
      end
      total++;
      if (got !== expv) begin
        bad++;
        $display("FAIL dir%0d_flags got=%h exp=%h", i, got, expv);
      end
      if (i == 0) begin
        total++;
        if (got[WIDTH] !== 1'b1) begin
          bad++;
          $display("FAIL add_cout got=%b exp=1", got[WIDTH]);
        end
      end
      if (i == 1) begin
        total++;
        if (got[WIDTH] !== 1'b0) begin
          bad++;
          $display("FAIL ripple_cout got=%b exp=0", got[WIDTH]);
        end
        total++;
        if (cn_seq !== 4'b0001) begin
          bad++;
          $display("FAIL ripple_cn_seq got=%b exp=0001", cn_seq);
        end
      end
      if (i >= 3) begin
        total++;
        if (got[WIDTH+1] !== (i == 3)) begin
          bad++;
          $display("FAIL dir%0d_aeqb got=%b exp=%b", i, got[WIDTH+1], (i == 3));
        end
      end
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00) begin
        bad++;
        $display("FAIL dir%0d_after_done got=%b exp=00", i, {busy, done});
      end
      total++;
      if ({aeqb, cout, result} !== expv) begin
        bad++;
        $display("FAIL dir%0d_hold got=%h exp=%h", i, {aeqb, cout, result}, expv);
      end
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] ra, rb;
    logic [3:0] rs;
    logic rm, rc;
    logic [WIDTH+1:0] got, expv;
    logic [3:0] cn_seq;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
      rm = 1'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rs, rm, rc, 1'b0, got, lat, cn_seq);
      expv = ref_op(ra, rb, rs, rm, rc);
      total++;
      if (got !== expv || lat !== NSLICE + 1) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h s=%h m=%b cin=%b got=%h lat=%0d exp=%h lat=%0d",
                 i, ra, rb, rs, rm, rc, got, lat, expv, NSLICE + 1);
      end
    end
  endtask

  task automatic test_operand_change;
    logic [WIDTH+1:0] got, expv;
    logic [3:0] cn_seq;
    int lat;
    run_op(16'h1357, 16'h2468, 4'b1001, 1'b0, 1'b1, 1'b1, got, lat, cn_seq);
    expv = ref_op(16'h1357, 16'h2468, 4'b1001, 1'b0, 1'b1);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL operand_change got=%h exp=%h", got, expv);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones;
    logic [WIDTH+1:0] got, expv;
    logic [3:0] cn_seq;
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; s = 4'b1001; m = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, cout, aeqb} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_flags got=%b exp=0000", {busy, done, cout, aeqb});
    end
    total++;
    if (result !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_result got=%h exp=0000", result);
    end
    total++;
    if ({slice_a, slice_b, slice_s, slice_m, slice_cn} !== 14'h0) begin
      bad++;
      $display("FAIL midrst_slice got=%h exp=0", {slice_a, slice_b, slice_s, slice_m, slice_cn});
    end
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL midrst_no_done got=%0d exp=0", dones);
    end
    run_op(16'h8001, 16'h7FFF, 4'b1001, 1'b0, 1'b1, 1'b0, got, lat, cn_seq);
    expv = ref_op(16'h8001, 16'h7FFF, 4'b1001, 1'b0, 1'b1);
    total++;
    if (got !== expv || lat !== NSLICE + 1) begin
      bad++;
      $display("FAIL midrst_fresh got=%h lat=%0d exp=%h lat=%0d", got, lat, expv, NSLICE + 1);
    end
  endtask

  task automatic test_ignored_start;
    logic [WIDTH+1:0] expv;
    int n, dones;
    expv = ref_op(16'h00F0, 16'h0F0F, 4'b1001, 1'b0, 1'b1);
    @(negedge clk);
    a = 16'h00F0; b = 16'h0F0F; s = 4'b1001; m = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    dones = 0;
    @(negedge clk);
    n++;
    a = 16'hDEAD; b = 16'hBEEF; s = 4'b0110; m = 1'b1; start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n !== NSLICE + 1) begin
      bad++;
      $display("FAIL ign_latency got=%0d exp=%0d", n, NSLICE + 1);
    end
    total++;
    if ({aeqb, cout, result} !== expv) begin
      bad++;
      $display("FAIL ign_result got=%h exp=%h", {aeqb, cout, result}, expv);
    end
    if (done) dones++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) begin
      if (done) dones++;
      @(negedge clk);
    end
    total++;
    if (dones !== 1) begin
      bad++;
      $display("FAIL ign_done_count got=%0d exp=1", dones);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH+1:0] expv;
    int ndone, prev, c;
    expv = ref_op(16'h0F0F, 16'h00FF, 4'b1001, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00FF; s = 4'b1001; m = 1'b0; cin = 1'b0; start = 1'b1;
    ndone = 0;
    prev = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        total++;
        if ({aeqb, cout, result} !== expv) begin
          bad++;
          $display("FAIL b2b_result%0d got=%h exp=%h", ndone, {aeqb, cout, result}, expv);
        end
        total++;
        if (k - prev !== ((ndone == 1) ? NSLICE + 1 : NSLICE + 2)) begin
          bad++;
          $display("FAIL b2b_gap%0d got=%0d exp=%0d", ndone, k - prev,
                   (ndone == 1) ? NSLICE + 1 : NSLICE + 2);
        end
        prev = k;
      end
    end
    start = 1'b0;
    total++;
    if (ndone !== 3) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=3", ndone);
    end
    c = 0;
    while (busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%b exp=0", busy);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_operand_change();
    test_reset_mid_run();
    test_ignored_start();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_word_seq.md
# alu_word_seq

Multi-cycle word sequencer for the 4-bit 74181-style combinational ALU slice. It accepts a WIDTH-bit operation request, drives the single shared slice one nibble per cycle (least-significant nibble first) and chains the slice carry-out back into the next nibble's carry-in. It assembles the WIDTH-bit result, final carry and word-level A=B flag, and reports completion with a start/busy/done handshake. The block sits between the processor control unit and the slice instance, replacing a WIDTH/4-slice ripple array with one slice plus this controller.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- a, b  in  WIDTH  operands.
- s  in  4  74181 function select.
- m  in  1  mode: 1 = logic, 0 = arithmetic.
- cin  in  1  carry into nibble 0, in 74181 Cn polarity; passed to the slice unmodified.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  assembled F.
- cout  out  1  carry-out of the last nibble.
- aeqb  out  1  AND of all per-nibble A=B outputs.
- slice_a, slice_b  out  4  nibble operands to the slice.
- slice_s  out  4  function select to the slice.
- slice_m  out  1  mode to the slice.
- slice_cn  out  1  carry-in to the slice.
- slice_f  in  4  slice F output.
- slice_cn4  in  1  slice carry-out.
- slice_aeqb  in  1  slice A=B output.

## Operation
- Constant NSLICE = WIDTH/4. Nibble index register idx is clog2(NSLICE) bits wide, minimum 1.
- States:
  - IDLE → RUN on start. On that edge: latch a, b, s, m into operand registers; carry register ← cin; idx ← 0; aeqb accumulator ← 1.
  - RUN: each cycle, then on the edge:
    - result[4*idx+3:4*idx] ← slice_f.
    - carry ← slice_cn4.
    - accumulator ← accumulator & slice_aeqb.
    - If idx == NSLICE-1, go to DONE; otherwise idx ← idx+1.
  - DONE → IDLE unconditionally; done = 1 during this cycle.
- Slice drive is combinational from registers only, with no combinational path from a/b/s/m/cin:
  - slice_a = a_reg nibble idx, slice_b = b_reg nibble idx.
  - slice_s = s_reg, slice_m = m_reg, slice_cn = carry.
  - Outside RUN, slice_a = slice_b = 0; slice_s, slice_m and slice_cn hold their register values.
- Carry is chained in mode 1 as well. The controller does not interpret m or s.
- cout = carry register; aeqb = accumulator. Both are valid from DONE onward.
- result, cout and aeqb hold their values through IDLE until the next accepted start.
- result bits for nibbles not yet processed keep their previous values during RUN. Outputs are only valid while done = 1 or afterwards.
- start in RUN or DONE is ignored, with no queuing. Operand inputs may change freely after the accepting edge.

## Timing
- Reset (rst = 1 at an edge), from any state including mid-RUN:
  - state ← IDLE, idx ← 0, all registers ← 0.
  - Outputs: busy = 0, done = 0, result = 0, cout = 0, aeqb = 0, slice_* = 0.
  - An aborted operation never produces done.
- start sampled high at edge E0: busy = 1 from E0 through the cycle after edge E0+NSLICE. done is high in that cycle (the DONE state).
- Latency from accepting edge to done high: NSLICE+1 edges, i.e. 5 for WIDTH = 16. Throughput is one operation per NSLICE+2 cycles.
- The earliest next start is accepted at the edge leaving DONE+1 (IDLE). A start held high continuously re-triggers at each IDLE visit.
- WIDTH = 4: a single RUN cycle, done at E0+2.
- rst and start high at the same edge: reset wins.

## Test plan
Use a bench-side 74181-conformant slice model (active-high data) with WIDTH = 16.
- Reset mid-RUN (assert at idx = 2) → next cycle busy = 0, result = 0x0000, no done pulse; a fresh start afterwards completes normally.
- A plus B: s = 4'b1001, m = 0, cin = 1 (no carry), a = 0x1234, b = 0x0FFF → done 5 edges after start, result = 0x2233, cout = 1 (no carry out).
- Carry ripple: same s/m/cin, a = 0xFFFF, b = 0x0001 → result = 0x0000, cout = 0 (carry out). slice_cn observed as 1, 0, 0, 0 across the four RUN cycles.
- Logic XOR / A=B: s = 4'b0110, m = 1, a = b = 0xA5A5 → result = 0x0000. Then s = 4'b0110, m = 0, cin = 1 (A minus B minus 1) with a = b = 0x3C3C → result = 0xFFFF, aeqb = 1. With a = 0x3C3C, b = 0x3C3B → aeqb = 0.
- start pulses at RUN idx = 1 and in the DONE cycle → ignored; exactly one done, and the result matches the first request. A start held high → back-to-back operations every 6 cycles.
- Operand change after the accepting edge (a flips to 0xFFFF at E0+1) → result reflects the latched operands.
